// File: rtl/keymem_arbiter_if.sv
// rtl/keymem_arbiter_if.sv - path-side and keymem-side key request bus of keymem_arbiter
interface keymem_arbiter_if #(
  parameter int NUM_PATHS    = 4,
  parameter int KEY_ID_WIDTH = 32,
  parameter int KEY_WIDTH    = 256
) ();
  logic [NUM_PATHS-1:0]              path_key_req;
  logic [NUM_PATHS*KEY_ID_WIDTH-1:0] path_key_id;
  logic [NUM_PATHS-1:0]              path_key_ack;
  logic                              path_key_valid;
  logic [KEY_WIDTH-1:0]              path_key;
  logic                              km_key_req;
  logic [KEY_ID_WIDTH-1:0]           km_key_id;
  logic                              km_key_ack;
  logic [KEY_WIDTH-1:0]              km_key;

  // master: the paths plus keymem surrounding the arbiter; slave: the arbiter itself
  modport master (
    output path_key_req, path_key_id, km_key_ack, km_key,
    input  path_key_ack, path_key_valid, path_key, km_key_req, km_key_id
  );

  modport slave (
    input  path_key_req, path_key_id, km_key_ack, km_key,
    output path_key_ack, path_key_valid, path_key, km_key_req, km_key_id
  );
endinterface

// File: rtl/keymem_arbiter.sv
// rtl/keymem_arbiter.sv - round-robin arbiter sharing one keymem key port among NUM_PATHS paths
module keymem_arbiter #(
  parameter int NUM_PATHS      = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int KEY_ID_WIDTH   = 32,
  parameter int KEY_WIDTH      = 256,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 key_clk,
  input  logic                 key_aresetn,
  keymem_arbiter_if.slave      bus,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]              r_state;
  logic [NUM_PATHS-1:0]    r_pending;
  logic [KEY_ID_WIDTH-1:0] r_id [NUM_PATHS];
  logic [IDX_WIDTH-1:0]    r_rr;
  logic [IDX_WIDTH-1:0]    r_grant;
  logic [TMR_W-1:0]        r_timer;
  logic                    r_busy;
  logic                    r_km_req;
  logic [KEY_ID_WIDTH-1:0] r_km_id;
  logic [NUM_PATHS-1:0]    r_ack;
  logic                    r_valid;
  logic [KEY_WIDTH-1:0]    r_key;
  logic [CNT_WIDTH-1:0]    r_drop_cnt;
  logic [CNT_WIDTH-1:0]    r_timeout_cnt;

  logic [NUM_PATHS-1:0]    w_grant_mask;
  logic [NUM_PATHS-1:0]    w_clr;
  logic [NUM_PATHS-1:0]    w_accept;
  logic [NUM_PATHS-1:0]    w_drop;
  logic [IDX_WIDTH-1:0]    w_rr_nx;
  logic [IDX_WIDTH-1:0]    w_sel;
  logic [IDX_WIDTH-1:0]    w_hi_sel;
  logic [IDX_WIDTH-1:0]    w_lo_sel;
  logic                    w_hi_found;

  assign w_grant_mask = NUM_PATHS'(1) << r_grant;
  // A path's pending bit clears in its RESP cycle; a new request that same cycle still wins.
  assign w_clr    = (r_state == S_RESP) ? w_grant_mask : '0;
  assign w_accept = bus.path_key_req & ~(r_pending & ~w_clr);
  assign w_drop   = bus.path_key_req & r_pending & ~w_clr;
  assign w_rr_nx  = (r_grant == IDX_WIDTH'(NUM_PATHS - 1)) ? '0 : r_grant + 1'b1;

  // Lowest pending index at or above rr_ptr, else lowest pending index overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int p = NUM_PATHS - 1; p >= 0; p--) begin
      if (r_pending[p]) begin
        w_lo_sel = IDX_WIDTH'(p);
        if (p >= int'(r_rr)) begin
          w_hi_sel   = IDX_WIDTH'(p);
          w_hi_found = 1'b1;
        end
      end
    end
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      for (int i = 0; i < NUM_PATHS; i++) r_id[i] <= '0;
      r_rr          <= '0;
      r_grant       <= '0;
      r_timer       <= '0;
      r_busy        <= 1'b0;
      r_km_req      <= 1'b0;
      r_km_id       <= '0;
      r_ack         <= '0;
      r_valid       <= 1'b0;
      r_key         <= '0;
      r_drop_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.path_key_req;
      for (int i = 0; i < NUM_PATHS; i++) begin
        if (w_accept[i]) r_id[i] <= bus.path_key_id[i*KEY_ID_WIDTH +: KEY_ID_WIDTH];
      end
      if ((|w_drop) && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_grant  <= w_sel;
            r_km_id  <= r_id[w_sel];
            r_km_req <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          r_km_req <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.km_key_ack) begin
            r_key   <= bus.km_key;
            r_valid <= 1'b1;
            r_ack   <= w_grant_mask;
            r_state <= S_RESP;
          end else if (r_timer == TMR_LAST) begin
            r_key   <= '0;
            r_valid <= 1'b0;
            r_ack   <= w_grant_mask;
            if (r_timeout_cnt != '1) r_timeout_cnt <= r_timeout_cnt + 1'b1;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_ack   <= '0;
          r_key   <= '0;
          r_valid <= 1'b0;
          r_rr    <= w_rr_nx;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.path_key_ack   = r_ack;
  assign bus.path_key_valid = r_valid;
  assign bus.path_key       = r_key;
  assign bus.km_key_req     = r_km_req;
  assign bus.km_key_id      = r_km_id;
  assign grant_idx          = r_grant;
  assign busy               = r_busy;
  assign drop_cnt           = r_drop_cnt;
  assign timeout_cnt        = r_timeout_cnt;

endmodule

// File: tb/tb_keymem_arbiter.sv
// tb/tb_keymem_arbiter.sv - directed self-checking bench for keymem_arbiter
module tb_keymem_arbiter;

  localparam int NP  = 4;
  localparam int IW  = 2;
  localparam int KIW = 32;
  localparam int KW  = 256;
  localparam int TO  = 16;
  localparam int CW  = 16;

  logic          key_clk = 1'b0;
  logic          key_aresetn = 1'b0;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] timeout_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_lat;
  logic km_en = 1'b1;
  logic late_ack = 1'b0;
  logic r_saw = 1'b0;
  logic r_saw_late = 1'b0;

  keymem_arbiter_if #(.NUM_PATHS(NP), .KEY_ID_WIDTH(KIW), .KEY_WIDTH(KW)) bus ();

  keymem_arbiter #(
    .NUM_PATHS(NP), .IDX_WIDTH(IW), .KEY_ID_WIDTH(KIW), .KEY_WIDTH(KW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .key_clk     (key_clk),
    .key_aresetn (key_aresetn),
    .bus         (bus),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #5 key_clk = ~key_clk;

  function automatic logic [KW-1:0] key_of(input logic [KIW-1:0] id);
    return {32{id[7:0] ^ 8'hB7}};
  endfunction

  // keymem model: acks one cycle after it sees km_key_req; late_ack injects a stray strobe
  always @(posedge key_clk) begin
    r_saw      = bus.km_key_req & km_en;
    r_saw_late = late_ack;
    #1;
    bus.km_key_ack = r_saw | r_saw_late;
    bus.km_key     = r_saw ? key_of(bus.km_key_id) : (r_saw_late ? {KW{1'b1}} : '0);
  end

  task automatic check(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge key_clk);
    #2;
  endtask

  task automatic set_req(input int p, input logic [KIW-1:0] id);
    bus.path_key_req[p]           = 1'b1;
    bus.path_key_id[p*KIW +: KIW] = id;
  endtask

  task automatic send();
    tick();
    bus.path_key_req = '0;
  endtask

  task automatic wait_ack(input string tag, input logic [NP-1:0] exp_ack, input logic exp_valid,
                          input logic [KW-1:0] exp_key, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.path_key_ack == '0 && n < 60);
    check({tag, "_ack"},   KW'(bus.path_key_ack),   KW'(exp_ack));
    check({tag, "_valid"}, KW'(bus.path_key_valid), KW'(exp_valid));
    check({tag, "_key"},   bus.path_key,            exp_key);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      seen = seen | (|bus.path_key_ack) | busy | bus.path_key_valid | (|bus.path_key);
    end
    check(tag, KW'(seen), KW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    bus.path_key_req = '0;
    bus.path_key_id  = '0;
    key_aresetn = 1'b0;
    repeat (2) tick();
    key_aresetn = 1'b1;
    tick();

    check("rst_busy",    KW'(busy),             KW'(0));
    check("rst_ack",     KW'(bus.path_key_ack), KW'(0));
    check("rst_kmreq",   KW'(bus.km_key_req),   KW'(0));
    check("rst_key",     bus.path_key,          KW'(0));
    check("rst_drop",    KW'(drop_cnt),         KW'(0));
    check("rst_timeout", KW'(timeout_cnt),      KW'(0));
    check("rst_grant",   KW'(grant_idx),        KW'(0));

    // single request, path 0
    set_req(0, 32'h12);
    send();
    tick();
    check("t1_kmreq", KW'(bus.km_key_req), KW'(1));
    check("t1_kmid",  KW'(bus.km_key_id),  KW'(32'h12));
    check("t1_busy",  KW'(busy),           KW'(1));
    wait_ack("t1", 4'b0001, 1'b1, {32{8'hA5}}, n_lat);
    check("t1_lat", KW'(n_lat), KW'(2));
    tick();
    check("t1_idle_busy", KW'(busy),             KW'(0));
    check("t1_idle_ack",  KW'(bus.path_key_ack), KW'(0));
    check("t1_idle_key",  bus.path_key,          KW'(0));

    // all four paths at once, served 0..3 from a fresh reset
    key_aresetn = 1'b0;
    tick();
    key_aresetn = 1'b1;
    tick();
    for (int p = 0; p < NP; p++) set_req(p, KIW'(32'h10 + p));
    send();
    for (int p = 0; p < NP; p++) begin
      wait_ack($sformatf("t2_p%0d", p), NP'(1 << p), 1'b1, key_of(KIW'(32'h10 + p)), n_lat);
      check($sformatf("t2_lat%0d", p), KW'(n_lat), KW'((p == 0) ? 3 : 4));
    end
    check("t2_grant", KW'(grant_idx), KW'(3));
    check("t2_drop",  KW'(drop_cnt),  KW'(0));

    // path 0 re-requests in its own RESP cycle while path 2 waits
    set_req(0, 32'h20);
    send();
    set_req(2, 32'h22);
    send();
    wait_ack("t3_p0a", 4'b0001, 1'b1, key_of(32'h20), n_lat);
    set_req(0, 32'h30);
    send();
    wait_ack("t3_p2", 4'b0100, 1'b1, key_of(32'h22), n_lat);
    check("t3_p2_lat", KW'(n_lat), KW'(3));
    wait_ack("t3_p0b", 4'b0001, 1'b1, key_of(32'h30), n_lat);
    check("t3_drop", KW'(drop_cnt), KW'(0));

    // duplicate request while pending is dropped
    set_req(1, 32'h5);
    send();
    set_req(1, 32'h6);
    send();
    check("t5_drop", KW'(drop_cnt),      KW'(1));
    check("t5_kmid", KW'(bus.km_key_id), KW'(32'h5));
    wait_ack("t5", 4'b0010, 1'b1, key_of(32'h5), n_lat);
    expect_quiet("t5_no_second", 6);

    // keymem never answers: timeout after TO WAIT cycles
    km_en = 1'b0;
    set_req(3, 32'h40);
    send();
    wait_ack("t4", 4'b1000, 1'b0, KW'(0), n_lat);
    check("t4_lat",     KW'(n_lat),       KW'(TO + 2));
    check("t4_timeout", KW'(timeout_cnt), KW'(1));
    tick();
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    expect_quiet("t4_late_ack", 5);
    check("t4_timeout_hold", KW'(timeout_cnt), KW'(1));

    // reset in the middle of WAIT
    set_req(0, 32'h50);
    send();
    repeat (3) tick();
    check("t6_pre_busy", KW'(busy), KW'(1));
    key_aresetn = 1'b0;
    #1;
    check("t6_busy",    KW'(busy),             KW'(0));
    check("t6_kmreq",   KW'(bus.km_key_req),   KW'(0));
    check("t6_kmid",    KW'(bus.km_key_id),    KW'(0));
    check("t6_ack",     KW'(bus.path_key_ack), KW'(0));
    check("t6_drop",    KW'(drop_cnt),         KW'(0));
    check("t6_timeout", KW'(timeout_cnt),      KW'(0));
    check("t6_grant",   KW'(grant_idx),        KW'(0));
    tick();
    key_aresetn = 1'b1;
    km_en = 1'b1;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    expect_quiet("t6_after", 24);
    check("t6_after_timeout", KW'(timeout_cnt), KW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
